data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and data_memory.
- Returns the word combinationally on a hit with no stall.
- On a miss, asserts cpu_busywait, writes back a dirty victim word-by-word, refills the block word-by-word, then resumes.
- Memory side uses the word-addressed read/write/busywait handshake that data_memory exposes.

Parameters:
- ADDR_WIDTH, 8, byte-address width on the CPU side; memory word address is ADDR_WIDTH-2 bits.
- SETS, 4, number of cache lines; power of two.
- WORDS_PER_BLOCK, 4, 32-bit words per line; power of two.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- cpu_read  in  1  load request; held until cpu_busywait is low.
- cpu_write  in  1  store request; held until cpu_busywait is low.
- cpu_address  in  ADDR_WIDTH  byte address; bits [1:0] ignored (word access only).
- cpu_writedata  in  32  store data.
- cpu_readdata  out  32  load data; valid when cpu_read=1 and cpu_busywait=0.
- cpu_busywait  out  1  stall request to the pipeline.
- mem_read  out  1  word read request to data_memory.
- mem_write  out  1  word write request to data_memory.
- mem_address  out  ADDR_WIDTH-2  word address to data_memory.
- mem_writedata  out  32  write-back word.
- mem_readdata  in  32  refill word.
- mem_busywait  in  1  high while data_memory is servicing the current request.

Behaviour:
- Address split (defaults): tag = addr[7:6], index = addr[5:4], word offset = addr[3:2].
- Per line state: valid bit, dirty bit, tag, WORDS_PER_BLOCK x 32 data.
- Access validity:
  - access = cpu_read XOR cpu_write.
  - read and write asserted together is a no access: no stall, no state change, cpu_readdata = 0.
- Hit detection: hit = valid[index] && tag[index]==addr tag, evaluated combinationally.
- Hit handling:
  - Read hit: cpu_readdata = line word, cpu_busywait = 0 in the same cycle; zero extra latency.
  - Write hit: word written and dirty set at the next posedge; cpu_busywait = 0.
- cpu_busywait = access && (!hit || state != IDLE). It is combinational, so it rises in the cycle of a missing request.
- FSM states IDLE, WRITEBACK, ALLOCATE, UPDATE:
  - IDLE: on access && !hit, go to WRITEBACK if valid && dirty, otherwise ALLOCATE; word counter := 0.
  - WRITEBACK:
    - Drives mem_write=1, mem_address = {victim tag, index, counter}, mem_writedata = victim word[counter].
    - A word completes on a posedge where mem_busywait=0 with the request asserted; counter increments on completion.
    - After the last word: dirty := 0, counter := 0, go to ALLOCATE.
  - ALLOCATE:
    - Drives mem_read=1, mem_address = {request tag, index, counter}.
    - On each completion, mem_readdata is written into word[counter]; counter increments.
    - After the last word: tag := request tag, valid := 1, dirty := 0, go to UPDATE.
  - UPDATE:
    - One cycle with no memory request and cpu_busywait still high; hit is re-evaluated.
    - Next cycle: IDLE, where the held request now hits. A store sets dirty then.
- mem_read and mem_write are never both high; both are 0 in IDLE and UPDATE. Memory outputs are decoded from state and counter.
- Refill latency: (1 + WORDS_PER_BLOCK x memory word latency + 1) cycles; a dirty victim adds WORDS_PER_BLOCK x latency.
- Reset (asynchronous, at any time including mid-refill or mid-writeback):
  - state := IDLE, counter := 0, all valid and dirty := 0.
  - mem_read, mem_write, cpu_busywait drop to 0 immediately; cpu_readdata = 0.
  - A partially written-back block is lost; this is accepted.
- A request withdrawn mid-miss does not abort the miss; the FSM completes the line fill.
- mem_busywait held high indefinitely: the FSM waits without timeout.

Decomposition:
- Package dcache_pkg:
  - State encoding localparams IDLE/WRITEBACK/ALLOCATE/UPDATE.
  - Derived widths: OFFSET_BITS = log2(WORDS_PER_BLOCK), INDEX_BITS = log2(SETS), TAG_BITS = ADDR_WIDTH-2-OFFSET_BITS-INDEX_BITS.
- Sub-module dcache_line_array:
  - Valid/dirty/tag/data storage with async clear.
  - One combinational read port.
  - One synchronous write port with word-select and tag/valid/dirty update enables.
- FSM and counter stay in data_cache.

Test Plan:
- Cold read miss:
  - Stimulus: after reset, memory word 0x05 = 0xDEADBEEF; cpu_read at address 0x14.
  - Response: busywait high, no writeback; mem_read for words 0x04..0x07; readdata 0xDEADBEEF when busywait falls.
- Read hit:
  - Stimulus: repeat the read of 0x14, then read 0x10.
  - Response: busywait 0 both cycles, no mem_read, data returned the same cycle.
- Write hit then dirty eviction:
  - Stimulus: write 0x12345678 to 0x14; read 0x54 (same index, new tag).
  - Response: mem_write words 0x04..0x07 with 0x12345678 at word 0x05, then mem_read 0x14..0x17; memory word 0x05 ends at 0x12345678.
- Write miss allocate:
  - Stimulus: write 0xA5A5A5A5 to 0x80.
  - Response: refill 0x20..0x23, then line word 0 = 0xA5A5A5A5 and dirty set; no mem_write until eviction.
- Illegal and latency:
  - Stimulus: cpu_read=cpu_write=1 at 0x14; then a miss with memory latency varied 1..5 cycles.
  - Response: busywait 0, state unchanged, readdata 0; for the miss, exactly WORDS_PER_BLOCK completions and correct data.
- Reset mid-refill:
  - Stimulus: assert reset during ALLOCATE, counter = 2.
  - Response: mem_read and busywait drop asynchronously; after release, re-reading the same address misses and fetches all 4 words.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM state encoding and the default address-field widths.
package dcache_pkg;

  localparam int DEF_ADDR_WIDTH      = 8;
  localparam int DEF_SETS            = 4;
  localparam int DEF_WORDS_PER_BLOCK = 4;

  localparam int OFFSET_BITS = $clog2(DEF_WORDS_PER_BLOCK);
  localparam int INDEX_BITS  = $clog2(DEF_SETS);
  localparam int TAG_BITS    = DEF_ADDR_WIDTH - 2 - OFFSET_BITS - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage for the data cache: valid, dirty, tag and block words per set.
// One combinational read port returning the whole line, one synchronous write
// port with a word write, a tag write (which also marks the line valid) and a
// dirty-bit write, all addressed by the same index.
module dcache_line_array #(
  parameter int SETS            = 4,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int INDEX_BITS      = 2,
  parameter int OFFSET_BITS     = 2,
  parameter int TAG_BITS        = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_BITS-1:0]  index,
  output logic                   valid,
  output logic                   dirty,
  output logic [TAG_BITS-1:0]    tag,
  output logic [31:0]            block [WORDS_PER_BLOCK],
  input  logic                   word_en,
  input  logic [OFFSET_BITS-1:0] word_sel,
  input  logic [31:0]            word_data,
  input  logic                   tag_en,
  input  logic [TAG_BITS-1:0]    tag_data,
  input  logic                   dirty_en,
  input  logic                   dirty_data
);

  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  logic [31:0]         data_q [SETS][WORDS_PER_BLOCK];

  // Line state update; everything clears asynchronously on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        tag_q[s] <= '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
          data_q[s][w] <= '0;
        end
      end
    end else begin
      if (word_en) begin
        data_q[index][word_sel] <= word_data;
      end
      if (tag_en) begin
        tag_q[index]   <= tag_data;
        valid_q[index] <= 1'b1;
      end
      if (dirty_en) begin
        dirty_q[index] <= dirty_data;
      end
    end
  end

  // Combinational read of the addressed line.
  always_comb begin
    valid = valid_q[index];
    dirty = dirty_q[index];
    tag   = tag_q[index];
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      block[w] = data_q[index][w];
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache. Hits are served
// combinationally; a miss stalls the pipeline while a dirty victim is written
// back word by word and the line is refilled word by word from data_memory.
module data_cache
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int SETS            = DEF_SETS,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [31:0]           cpu_writedata,
  output logic [31:0]           cpu_readdata,
  output logic                  cpu_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-3:0] mem_address,
  output logic [31:0]           mem_writedata,
  input  logic [31:0]           mem_readdata,
  input  logic                  mem_busywait
);

  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic [OFF_W-1:0] req_offset;
  logic [1:0]       unused_byte_offset;

  assign req_tag            = cpu_address[ADDR_WIDTH-1 -: TAG_W];
  assign req_index          = cpu_address[2+OFF_W +: IDX_W];
  assign req_offset         = cpu_address[2 +: OFF_W];
  assign unused_byte_offset = cpu_address[1:0];

  state_t           state, state_next;
  logic [OFF_W-1:0] count, count_next;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_index;

  logic [IDX_W-1:0] line_index;
  logic             line_valid, line_dirty;
  logic [TAG_W-1:0] line_tag;
  logic [31:0]      line_block [WORDS_PER_BLOCK];

  logic             word_en, tag_en, dirty_en, dirty_data;
  logic [OFF_W-1:0] word_sel;
  logic [31:0]      word_data;

  logic access, hit, last;

  // Outside IDLE the line being filled is pinned to the latched miss index,
  // so a request that changes or is withdrawn mid-miss cannot redirect it.
  assign line_index = (state == IDLE) ? req_index : miss_index;
  assign access     = cpu_read ^ cpu_write;
  assign hit        = line_valid && (line_tag == req_tag);
  assign last       = (count == OFF_W'(WORDS_PER_BLOCK - 1));

  assign cpu_busywait = !reset && access && (!hit || state != IDLE);
  assign cpu_readdata = (!reset && cpu_read && !cpu_write && hit && state == IDLE)
                        ? line_block[req_offset] : 32'd0;

  dcache_line_array #(
    .SETS            (SETS),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .INDEX_BITS      (IDX_W),
    .OFFSET_BITS     (OFF_W),
    .TAG_BITS        (TAG_W)
  ) lines (
    .clock      (clock),
    .reset      (reset),
    .index      (line_index),
    .valid      (line_valid),
    .dirty      (line_dirty),
    .tag        (line_tag),
    .block      (line_block),
    .word_en    (word_en),
    .word_sel   (word_sel),
    .word_data  (word_data),
    .tag_en     (tag_en),
    .tag_data   (miss_tag),
    .dirty_en   (dirty_en),
    .dirty_data (dirty_data)
  );

  // State, word counter and the miss request latched when a miss begins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      miss_tag   <= '0;
      miss_index <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (state == IDLE && access && !hit) begin
        miss_tag   <= req_tag;
        miss_index <= req_index;
      end
    end
  end

  // Next-state, memory request decode and line-array write controls.
  always_comb begin
    state_next    = state;
    count_next    = count;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = 32'd0;
    word_en       = 1'b0;
    word_sel      = req_offset;
    word_data     = cpu_writedata;
    tag_en        = 1'b0;
    dirty_en      = 1'b0;
    dirty_data    = 1'b0;
    case (state)
      IDLE: begin
        if (access && !hit) begin
          count_next = '0;
          state_next = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
        end else if (cpu_write && !cpu_read && hit) begin
          word_en    = 1'b1;
          dirty_en   = 1'b1;
          dirty_data = 1'b1;
        end
      end
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {line_tag, miss_index, count};
        mem_writedata = line_block[count];
        if (!mem_busywait) begin
          count_next = count + 1'b1;
          if (last) begin
            dirty_en   = 1'b1;
            dirty_data = 1'b0;
            count_next = '0;
            state_next = ALLOCATE;
          end
        end
      end
      ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = {miss_tag, miss_index, count};
        if (!mem_busywait) begin
          word_en    = 1'b1;
          word_sel   = count;
          word_data  = mem_readdata;
          count_next = count + 1'b1;
          if (last) begin
            tag_en     = 1'b1;
            dirty_en   = 1'b1;
            dirty_data = 1'b0;
            count_next = '0;
            state_next = UPDATE;
          end
        end
      end
      UPDATE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: a behavioural word memory with
// adjustable latency, a transaction monitor on the memory port and a
// scoreboard of expected load data.
module tb_data_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [7:0]  cpu_address;
  logic [31:0] cpu_writedata, cpu_readdata;
  logic        cpu_busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_busywait;

  always #5 clock = ~clock;

  data_cache dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .cpu_busywait  (cpu_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  // Memory model: each word takes wait_cycles stall cycles then completes.
  logic [31:0] mem_model [64];
  int          wait_cycles = 0;
  int          cnt = 0;

  assign mem_busywait = (mem_read || mem_write) && (cnt < wait_cycles);
  assign mem_readdata = mem_model[mem_address];

  always @(posedge clock) begin
    if (reset) begin
      cnt <= 0;
    end else if (mem_read || mem_write) begin
      if (cnt >= wait_cycles) begin
        cnt <= 0;
        if (mem_write) mem_model[mem_address] <= mem_writedata;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  // Monitor of completed memory transactions.
  logic [5:0]  rd_log [$];
  logic [5:0]  wr_log_a [$];
  logic [31:0] wr_log_d [$];
  int          both_high = 0;

  always @(posedge clock) begin
    if (mem_read && mem_write) both_high <= both_high + 1;
    if (!reset && mem_read && !mem_busywait) rd_log.push_back(mem_address);
    if (!reset && mem_write && !mem_busywait) begin
      wr_log_a.push_back(mem_address);
      wr_log_d.push_back(mem_writedata);
    end
  end

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_log_a.delete();
    wr_log_d.delete();
  endtask

  // Drive one request, wait (bounded) for the stall to end, compare load data.
  task automatic cpu_access(input string tag, input logic rd, input logic wr,
                            input logic [7:0] addr, input logic [31:0] wdata,
                            output int waited);
    @(negedge clock);
    cpu_read      = rd;
    cpu_write     = wr;
    cpu_address   = addr;
    cpu_writedata = wdata;
    #1;
    waited = 0;
    while (cpu_busywait && waited < 400) begin
      @(negedge clock);
      #1;
      waited++;
    end
    check_eq({tag, "_stall_end"}, {31'd0, cpu_busywait}, 32'd0);
    if (rd && exp_q.size() > 0) check_eq({tag, "_data"}, cpu_readdata, exp_q.pop_front());
    @(posedge clock);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [7:0] addr,
                         input logic [31:0] exp, output int waited);
    exp_q.push_back(exp);
    cpu_access(tag, 1'b1, 1'b0, addr, 32'd0, waited);
  endtask

  task automatic check_reads(input string tag, input logic [5:0] base);
    check_eq({tag, "_rd_count"}, rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++)
      check_eq({tag, "_rd_addr"}, {26'd0, rd_log[i]}, {26'd0, base + 6'(i)});
  endtask

  int n;
  logic [7:0]  lat_addr [5] = '{8'hA8, 8'hEC, 8'h38, 8'h64, 8'hC4};
  logic [5:0]  lat_word [5] = '{6'h2A, 6'h3B, 6'h0E, 6'h19, 6'h31};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem_model[i] = 32'h1000_0000 + i;
    mem_model[5] = 32'hDEAD_BEEF;
    reset = 1'b1;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 8'h14; cpu_writedata = 0;
    repeat (2) @(negedge clock);
    #1;
    check_eq("rst_busywait", {31'd0, cpu_busywait}, 0);
    check_eq("rst_mem_read", {31'd0, mem_read}, 0);
    check_eq("rst_mem_write", {31'd0, mem_write}, 0);
    check_eq("rst_readdata", cpu_readdata, 0);
    cpu_read = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Cold read miss
    clear_logs();
    do_read("cold", 8'h14, 32'hDEAD_BEEF, n);
    check_eq("cold_cycles", n, 6);
    check_reads("cold", 6'h04);
    check_eq("cold_no_wb", wr_log_a.size(), 0);

    // Read hits
    clear_logs();
    do_read("hit14", 8'h14, 32'hDEAD_BEEF, n);
    check_eq("hit14_cycles", n, 0);
    do_read("hit10", 8'h10, 32'h1000_0004, n);
    check_eq("hit10_cycles", n, 0);
    check_eq("hit_no_memrd", rd_log.size(), 0);

    // Write hit, then dirty eviction by a conflicting read
    cpu_access("wrhit", 1'b0, 1'b1, 8'h14, 32'h1234_5678, n);
    check_eq("wrhit_cycles", n, 0);
    clear_logs();
    do_read("evict", 8'h54, 32'h1000_0015, n);
    check_eq("evict_cycles", n, 10);
    check_eq("evict_wr_count", wr_log_a.size(), 4);
    for (int i = 0; i < 4 && i < wr_log_a.size(); i++) begin
      check_eq("evict_wr_addr", {26'd0, wr_log_a[i]}, 32'h04 + i);
      check_eq("evict_wr_data", wr_log_d[i], (i == 1) ? 32'h1234_5678 : 32'h1000_0004 + i);
    end
    check_reads("evict", 6'h14);
    check_eq("evict_mem5", mem_model[5], 32'h1234_5678);

    // Write miss allocates, dirty line written back only on eviction
    clear_logs();
    cpu_access("wrmiss", 1'b0, 1'b1, 8'h80, 32'hA5A5_A5A5, n);
    check_eq("wrmiss_cycles", n, 6);
    check_reads("wrmiss", 6'h20);
    check_eq("wrmiss_no_wb", wr_log_a.size(), 0);
    do_read("wrmiss_hit", 8'h80, 32'hA5A5_A5A5, n);
    check_eq("wrmiss_hit_cycles", n, 0);
    clear_logs();
    do_read("evict0", 8'h00, 32'h1000_0000, n);
    check_eq("evict0_wr_count", wr_log_a.size(), 4);
    if (wr_log_a.size() == 4) begin
      check_eq("evict0_wr_addr0", {26'd0, wr_log_a[0]}, 32'h20);
      check_eq("evict0_wr_data0", wr_log_d[0], 32'hA5A5_A5A5);
      check_eq("evict0_wr_data1", wr_log_d[1], 32'h1000_0021);
    end
    check_eq("evict0_mem20", mem_model[6'h20], 32'hA5A5_A5A5);

    // Read and write together: no access
    clear_logs();
    exp_q.push_back(32'd0);
    cpu_access("illegal", 1'b1, 1'b1, 8'h14, 32'hFFFF_FFFF, n);
    check_eq("illegal_cycles", n, 0);
    do_read("after_illegal", 8'h54, 32'h1000_0015, n);
    check_eq("after_illegal_cycles", n, 0);
    check_eq("illegal_no_mem", rd_log.size() + wr_log_a.size(), 0);

    // Misses with memory latency 1..5 cycles per word
    for (int l = 1; l <= 5; l++) begin
      wait_cycles = l - 1;
      clear_logs();
      do_read("lat", lat_addr[l-1], 32'h1000_0000 + lat_word[l-1], n);
      check_eq("lat_cycles", n, 2 + 4 * l);
      check_reads("lat", {lat_word[l-1][5:2], 2'b00});
    end

    // Asynchronous reset in the middle of a refill
    wait_cycles = 2;
    clear_logs();
    @(negedge clock);
    cpu_read = 1'b1; cpu_address = 8'h14;
    n = 0;
    while (rd_log.size() < 2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_eq("mid_fill_words", rd_log.size(), 2);
    check_eq("pre_rst_mem_read", {31'd0, mem_read}, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_mem_read", {31'd0, mem_read}, 0);
    check_eq("async_busywait", {31'd0, cpu_busywait}, 0);
    check_eq("async_readdata", cpu_readdata, 0);
    @(negedge clock);
    cpu_read = 1'b0;
    reset = 1'b0;
    clear_logs();
    do_read("post_rst", 8'h14, 32'h1234_5678, n);
    check_eq("post_rst_cycles", n, 14);
    check_reads("post_rst", 6'h04);

    check_eq("never_both_high", both_high, 0);
    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
